// File: rtl/adc_cur_avg_pkg.sv
// ============================================================================
//  Module      : adc_pkg
//  Description : Shared types, constants and lane helpers for the quad
//                motor-current boxcar averager (adc_cur_avg).
//                Lane packing: ch1 = [15:0] ... ch4 = [63:48].
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_pkg;

    // Board-fixed channel count and ADC sample width; default decimation.
    localparam int c_nch           = 4;
    localparam int c_w             = 16;
    localparam int c_log2n_default = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] ch_t;

    // Extract one W-bit lane from a packed NCH*W bus.
    function automatic logic [c_w-1:0] lane_get(
        input logic [c_nch*c_w-1:0] bus,
        input ch_t                  ch
    );
        return bus[ch*c_w +: c_w];
    endfunction

    // Return the bus with one lane replaced.
    function automatic logic [c_nch*c_w-1:0] lane_set(
        input logic [c_nch*c_w-1:0] bus,
        input ch_t                  ch,
        input logic [c_w-1:0]       val
    );
        logic [c_nch*c_w-1:0] r;
        r = bus;
        r[ch*c_w +: c_w] = val;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_avg_div.sv
// ============================================================================
//  Module      : adc_avg_div
//  Description : Combinational divider for the averager's final sum.
//                Divides a (W+LOG2N)-bit sum by 2^LOG2N and returns W bits.
//                ADC_AVG_ROUND_EN defined   -> round to nearest (half up)
//                ADC_AVG_ROUND_EN undefined -> truncation
//  Ports       : i_sum [W+LOG2N-1:0]  final accumulated sum
//                o_avg [W-1:0]        averaged sample
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_avg_div #(
    parameter int W     = 16,
    parameter int LOG2N = 3
) (
    input  logic [W+LOG2N-1:0] i_sum,
    output logic [W-1:0]       o_avg
);

`ifdef ADC_AVG_ROUND_EN
    // One extra bit so the rounding constant can never wrap the sum; the
    // shifted result still fits W bits because max sum + half < 2^(W+LOG2N).
    localparam logic [W+LOG2N:0] c_half = {{(W+LOG2N){1'b0}}, 1'b1} << (LOG2N-1);

    logic [W+LOG2N:0] w_rnd;
    logic             w_unused_bits;

    assign w_rnd         = {1'b0, i_sum} + c_half;
    assign o_avg         = w_rnd[LOG2N +: W];
    assign w_unused_bits = ^{w_rnd[W+LOG2N], w_rnd[LOG2N-1:0]};
`else
    logic w_unused_bits;

    assign o_avg         = i_sum[LOG2N +: W];
    assign w_unused_bits = ^i_sum[LOG2N-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/adc_cur_avg.sv
// ============================================================================
//  Module      : adc_cur_avg
//  Description : Boxcar averager for four 16-bit motor-current channels over
//                2^LOG2N conversion sets. One shared adder is time-multiplexed
//                across channels (one channel per clock) by a small FSM.
//                Optional macro ADC_AVG_ROUND_EN selects round-to-nearest in
//                the final divide instead of truncation.
//  Ports       : clkadc      ADC clock
//                reset       synchronous active-low reset
//                samp_valid  pulse: cur_in holds a fresh set of conversions
//                cur_in      packed currents, ch1 = [15:0] .. ch4 = [63:48]
//                avg_out     packed averaged currents, same packing
//                avg_valid   pulse: avg_out fully updated
//                busy        high whenever the FSM is not idle
//                overrun     sticky: samp_valid arrived while busy
//                clr_ovr     clears overrun (a coincident new overrun wins)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_cur_avg
    import adc_pkg::*;
#(
    parameter int NCH   = c_nch,
    parameter int W     = c_w,
    parameter int LOG2N = c_log2n_default
) (
    input  logic             clkadc,
    input  logic             reset,
    input  logic             samp_valid,
    input  logic [NCH*W-1:0] cur_in,
    output logic [NCH*W-1:0] avg_out,
    output logic             avg_valid,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_ovr
);

    localparam int               c_aw       = W + LOG2N;
    localparam logic [LOG2N-1:0] c_cnt_last = '1;
    localparam ch_t              c_ch_last  = ch_t'(NCH-1);

    state_t           r_state;
    state_t           w_state_next;
    ch_t              r_ch;
    logic [LOG2N-1:0] r_cnt;
    logic [c_aw-1:0]  r_acc [NCH];
    logic [NCH*W-1:0] r_snap;
    logic [NCH*W-1:0] r_avg;
    logic             r_overrun;

    logic [W-1:0]     w_snap_lane;
    logic [c_aw-1:0]  w_sum;
    logic [W-1:0]     w_div;
    logic             w_last;

    // Shared datapath: the single adder serves whichever channel r_ch selects.
    assign w_snap_lane = lane_get(r_snap, r_ch);
    assign w_sum       = r_acc[r_ch] + {{LOG2N{1'b0}}, w_snap_lane};
    assign w_last      = (r_cnt == c_cnt_last);

    adc_avg_div #(
        .W     (W),
        .LOG2N (LOG2N)
    ) u_div (
        .i_sum (w_sum),
        .o_avg (w_div)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clkadc) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (samp_valid) begin
                    w_state_next = ACC;
                end
            end
            ACC: begin
                if (r_ch == c_ch_last) begin
                    w_state_next = w_last ? DONE : IDLE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clkadc) begin
        if (!reset) begin
            r_ch      <= '0;
            r_cnt     <= '0;
            r_snap    <= '0;
            r_avg     <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (samp_valid) begin
                        r_snap <= cur_in;
                        r_ch   <= '0;
                    end
                end
                ACC: begin
                    if (w_last) begin
                        // Final set: publish this lane and restart its sum.
                        r_avg       <= lane_set(r_avg, r_ch, w_div);
                        r_acc[r_ch] <= '0;
                    end else begin
                        r_acc[r_ch] <= w_sum;
                    end
                    r_ch <= r_ch + 2'd1;
                    if (r_ch == c_ch_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase

            // A set arriving while busy is dropped; the sticky flag records
            // it and takes priority over a coincident clear.
            if (samp_valid && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end else if (clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign avg_out   = r_avg;
    assign avg_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: doc/adc_cur_avg.md
Name: adc_cur_avg

Overview:
Downstream consumer of the quad current-feedback ADC stage. Boxcar-averages the four 16-bit motor-current channels over 2^LOG2N conversion sets, producing a decimated, low-noise current word per channel for the register file and control loop. Uses one shared adder, time-multiplexed across channels by a small FSM.

Parameters:
NCH, 4, number of current channels (fixed at 4 for this board)
W, 16, ADC sample width (unsigned, LTC1864 format)
LOG2N, 3, log2 of samples per average; legal range 1..6

Ports:
clkadc  input  1  ADC clock, same domain as the ADC serial stage
reset  input  1  synchronous active-low reset
samp_valid  input  1  one-cycle pulse: cur_in holds a fresh set of 4 conversions
cur_in  input  NCH*W  packed currents; ch1 = [15:0], ch4 = [63:48]
avg_out  output  NCH*W  packed averaged currents, same packing
avg_valid  output  1  one-cycle pulse: avg_out fully updated
busy  output  1  high whenever state != IDLE
overrun  output  1  sticky: samp_valid arrived while busy
clr_ovr  input  1  clears overrun

Behaviour:
- One clock (clkadc); reset is synchronous and active-low. Everything is sampled on rising clkadc; reset is honoured only at a clock edge.
- Reset (reset==0 at an edge) sets:
  - state=IDLE, all accumulators=0, sample count=0, channel index=0;
  - avg_out=0, avg_valid=0, overrun=0.
- Reset mid-operation aborts the partial average. A full 2^LOG2N fresh sets are needed before the next avg_valid.
- Accumulators: NCH × (W+LOG2N) bits, unsigned. Sample count: LOG2N bits.
- Shared datapath: one (W+LOG2N)-bit adder; snapshot register NCH×W.
- FSM states:
  - IDLE: on samp_valid, latch cur_in into snapshot, set ch=0, go to ACC.
  - ACC: one channel per cycle; ch steps 0..3.
    - Not last sample (count != 2^LOG2N-1): acc[ch] <= acc[ch] + snap[ch].
    - Last sample: avg_out[ch] <= (acc[ch]+snap[ch]) >> LOG2N, then acc[ch] <= 0.
    - After ch=3, count increments (wraps to 0). Go to DONE if it was the last sample, else to IDLE.
  - DONE: avg_valid=1 for exactly this cycle, then go to IDLE.
- Timing: samp_valid in cycle 0 → ACC in cycles 1-4 → DONE in cycle 5 (avg_valid high) → IDLE in cycle 6. On non-final sets, IDLE resumes in cycle 5.
- avg_out updates channel by channel in cycles 1-4. Consumers read it only on or after avg_valid. Each channel value holds until the next final set.
- samp_valid while busy:
  - the set is dropped, and neither count nor accumulators change;
  - overrun <= 1.
- If a new overrun and clr_ovr occur in the same cycle, the set wins.
- The ADC stage's sample period far exceeds 6 clkadc cycles, so overrun indicates a system fault.
- No overflow is possible: the maximum sum, 2^LOG2N × 0xFFFF, fits in W+LOG2N bits.

Optional Feature:
ADC_AVG_ROUND_EN
- Defined: round-to-nearest. Final value = (acc+snap+2^(LOG2N-1)) >> LOG2N, computed at W+LOG2N+1 bits. The result is ≤ 0xFFFF, so no saturation is needed.
- Undefined: truncation (plain shift).
- Latency is identical with and without the macro.

Decomposition:
- Shared package adc_pkg:
  - constants NCH, W, default LOG2N;
  - FSM state enum {IDLE, ACC, DONE};
  - channel index type (2 bits);
  - lane-slice helpers for the packed buses.
- One natural sub-module, adc_avg_div: takes the final sum, applies the shift and the ADC_AVG_ROUND_EN rounding, and returns W bits. It is combinational and has a single instance on the shared adder output.

Test Plan:
- Constant input, LOG2N=3: 8 sets with ch1..ch4 = 0x1000, 0x2000, 0x0000, 0x8000 → avg_valid in cycle 5 after the 8th samp_valid; avg_out = those same values; no avg_valid after sets 1-7.
- Ramp on ch2: values 0..7 over 8 sets → sum 28. Avg 3 without the macro; avg 4 with ADC_AVG_ROUND_EN.
- Full scale: 0xFFFF on all channels for 8 sets → avg_out = 0xFFFF per lane in both builds; no wrap.
- Overrun:
  - samp_valid in cycle 2 of ACC → overrun=1; that set is ignored, so a 9th valid set is required before avg_valid.
  - clr_ovr alone → overrun=0.
  - clr_ovr coinciding with a new overrun → overrun stays 1.
- Reset mid-ACC: 5 sets, then reset=0 for one cycle during ACC → avg_out=0, busy=0. The next avg_valid comes only after 8 further sets; the average reflects only those sets.
- Back-to-back: samp_valid exactly in cycle 6 after a final set → accepted, no overrun. samp_valid in cycle 5 (DONE) → overrun=1.
